branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Dynamic conditional-branch predictor at the fetch end of the branch-resolution loop.
//  It produces the branch_estimation bit and the predicted next PC that travel down the pipe.
//  It trains on the outcome that the EX-stage branch logic resolves.
//  Storage: a table of 2-bit saturating counters indexed by PC. Lookup is combinational; update is registered.
// PARAMETERS
//  INDEX_BITS  6   log2 of table entries (64); index = pc[INDEX_BITS+1:2]
//  XLEN        32  address/immediate width
// PORTS
//  clk                        in   1     system clock, all state updates on rising edge
//  reset_n                    in   1     asynchronous, active-low reset
//  if_branch                  in   1     IF-stage instruction is a conditional branch (B-type)
//  if_pc                      in   XLEN  PC of the IF-stage instruction
//  if_imm                     in   XLEN  sign-extended B-type immediate of the IF-stage instruction
//  branch_estimation          out  1     predicted taken (1) / not taken (0)
//  branch_target_predicted    out  XLEN  next fetch PC implied by the prediction
//  ex_branch                  in   1     EX-stage instruction is a resolved conditional branch (update strobe)
//  ex_pc                      in   XLEN  PC of the resolving branch
//  ex_branch_taken            in   1     actual outcome from branch logic
//  ex_branch_prediction_miss  in   1     resolution disagreed with the carried estimate
//  miss_count                 out  16    saturating count of mispredictions since reset
// BEHAVIOUR
//  - Counter encoding: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11. Predict taken iff counter[1]=1.
//  - Reset (reset_n=0, asynchronous): every entry is set to WNT, miss_count=0, and the GHR (if present) is 0.
//    Outputs after reset: branch_estimation=0.
//  - Lookup (0 cycles, combinational):
//    - if_branch=0: branch_estimation=0, target=if_pc+4.
//    - if_branch=1: estimation=table[idx][1]; target = estimation ? if_pc+if_imm : if_pc+4.
//    - Sums are taken modulo 2^XLEN (wrap, no overflow flag).
//  - Update (1 cycle, registered): on the posedge with ex_branch=1, table[ex_idx] moves one step.
//    - Taken: step toward ST; no change at ST.
//    - Not taken: step toward SNT; no change at SNT.
//    - ex_branch=0: table unchanged, and the taken/miss inputs are ignored.
//  - Same-cycle read/write to the same index: the lookup returns the pre-update value. There is no bypass.
//  - Aliasing: different PCs with an equal index share one counter. No tags.
//  - miss_count: +1 on each posedge with ex_branch & ex_branch_prediction_miss; it holds at 16'hFFFF.
//  - Reset asserted mid-operation: an update pending on that edge is discarded and the state is cleared immediately.
//  - Any X on if_* while if_branch=0 must not propagate into branch_estimation.
// CONFIGURATION
//  BRANCH_PREDICTOR_GSHARE_EN
//    Defined: an INDEX_BITS-wide global history register (GHR) is added.
//      - Lookup index = if_pc[INDEX_BITS+1:2] ^ GHR.
//      - Update index = ex_pc[INDEX_BITS+1:2] ^ GHR, using the GHR value before the shift.
//      - GHR shifts left on each ex_branch, inserting ex_branch_taken at the LSB.
//      - History is non-speculative: it updates at resolve only.
//    Undefined: bimodal indexing by PC only, and no GHR is instantiated.
// STRUCTURE
//  Shared header branch.vh gains the counter-state defines:
//    `BHT_SNT, `BHT_WNT, `BHT_WT, `BHT_ST
//  Sub-module bht_counter_next (combinational): maps (state, taken) to the next state. It is reused by later predictors.
//  The table is a reg array. Target adders are local.
// TESTING
//  1. Reset, then if_branch=1, if_pc=0x1000, if_imm=0x100 -> est=0, target=0x00001004, miss_count=0.
//  2. One update ex_branch=1, ex_pc=0x1000, taken=1, miss=1 -> next cycle est=1, target=0x00001100, miss_count=1.
//  3. Three more taken updates, then one not-taken -> counter ST->WT, est stays 1; a second not-taken -> est=0.
//  4. Alias check (bimodal): train 0x1000 to ST, then look up if_pc=0x1100 -> est=1 (shared index 0).
//  5. Update and lookup of 0x1000 in the same cycle from WNT with taken -> est=0 that cycle, est=1 the next cycle.
//  6. Pull reset_n low between clock edges after training -> est=0 immediately, miss_count=0, table back to WNT.
//  7. GSHARE build: alternate taken/not-taken at 0x1000 for 8 resolves -> prediction follows the alternation (0 misses after warm-up).

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the conditional-branch predictor family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the 2-bit saturating counter encoding (SNT/WNT/WT/ST) and the
// default geometry. Every predictor block that trains these counters imports it.
package branch_predictor_pkg;

  localparam int BP_INDEX_BITS = 6;   // 64-entry table
  localparam int BP_XLEN       = 32;
  localparam int BP_MISS_W     = 16;

  // Counter states. Bit 1 is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_state_e;

  // Predicts taken when the counter is in the upper half.
  function automatic logic bht_predict_taken(bht_state_e s);
    return s[1];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side resolve signals of the branch predictor.
// Latency: n/a (bundle of wires).
// Backpressure: none; lookup is always answered, updates are single-cycle strobes.
//
// master: pipeline side (drives IF lookup and EX resolve, receives prediction).
// slave : predictor side.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  // IF-stage lookup
  logic            if_branch;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_imm;
  logic            branch_estimation;
  logic [XLEN-1:0] branch_target_predicted;
  // EX-stage resolve / training
  logic            ex_branch;
  logic [XLEN-1:0] ex_pc;
  logic            ex_branch_taken;
  logic            ex_branch_prediction_miss;
  logic [15:0]     miss_count;

  modport master (
    output if_branch, if_pc, if_imm,
    output ex_branch, ex_pc, ex_branch_taken, ex_branch_prediction_miss,
    input  branch_estimation, branch_target_predicted, miss_count
  );

  modport slave (
    input  if_branch, if_pc, if_imm,
    input  ex_branch, ex_pc, ex_branch_taken, ex_branch_prediction_miss,
    output branch_estimation, branch_target_predicted, miss_count
  );
endinterface

// File: rtl/branch_predictor_bht_counter_next.sv
// Next-state function of a 2-bit saturating branch counter.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
//
// Ports: state_i (current counter), taken_i (resolved outcome),
//        state_o (counter after one training step, saturating at SNT/ST).
module bht_counter_next
  import branch_predictor_pkg::*;
(
  input  bht_state_e state_i,
  input  logic       taken_i,
  output bht_state_e state_o
);

  always_comb begin
    state_o = state_i;
    case (state_i)
      BHT_SNT: state_o = taken_i ? BHT_WNT : BHT_SNT;
      BHT_WNT: state_o = taken_i ? BHT_WT  : BHT_SNT;
      BHT_WT:  state_o = taken_i ? BHT_ST  : BHT_WNT;
      BHT_ST:  state_o = taken_i ? BHT_ST  : BHT_WT;
      default: state_o = state_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic conditional-branch predictor: 2-bit counter table, lookup at IF, training at EX.
// Latency: prediction/target combinational (0 cycles); training visible 1 cycle after the resolve edge.
// Backpressure: none; every lookup is answered and every ex_branch strobe is absorbed.
//
// Ports: clk, reset_n (async, active low); bp (branch_predictor_if.slave):
//   if_branch/if_pc/if_imm -> branch_estimation/branch_target_predicted,
//   ex_branch/ex_pc/ex_branch_taken/ex_branch_prediction_miss -> training, miss_count.
// Optional build macro: BRANCH_PREDICTOR_GSHARE_EN (gshare indexing with a global
// history register updated at resolve time); undefined gives plain bimodal indexing.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS,
  parameter int XLEN       = BP_XLEN
) (
  input  logic               clk,
  input  logic               reset_n,
  branch_predictor_if.slave  bp
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  bht_state_e             table_q [ENTRIES];
  bht_state_e             lookup_state;
  bht_state_e             update_state;
  bht_state_e             update_state_d;
  logic [INDEX_BITS-1:0]  lookup_idx;
  logic [INDEX_BITS-1:0]  update_idx;
  logic                   est;
  logic [XLEN-1:0]        tgt_taken;
  logic [XLEN-1:0]        tgt_seq;
  logic [15:0]            miss_count_q;
  logic [15:0]            miss_count_d;

  // Only the index bits of the resolving PC matter; the rest is intentionally dropped.
  logic unused_ex_pc_bits;
  assign unused_ex_pc_bits = ^{bp.ex_pc[XLEN-1:INDEX_BITS+2], bp.ex_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;
  logic [INDEX_BITS-1:0] ghr_d;

  // Both lookup and update hash with the history as it stands before this
  // edge's shift, so a same-cycle lookup and resolve see the same context.
  assign lookup_idx = bp.if_branch ? (bp.if_pc[INDEX_BITS+1:2] ^ ghr_q) : '0;
  assign update_idx = bp.ex_pc[INDEX_BITS+1:2] ^ ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (bp.ex_branch) begin
      ghr_d = {ghr_q[INDEX_BITS-2:0], bp.ex_branch_taken};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  // Index is forced to 0 for non-branches so an unknown PC never reaches the table read.
  assign lookup_idx = bp.if_branch ? bp.if_pc[INDEX_BITS+1:2] : '0;
  assign update_idx = bp.ex_pc[INDEX_BITS+1:2];
`endif

  // Lookup reads the registered table: a same-cycle update is not bypassed.
  assign lookup_state = table_q[lookup_idx];
  assign est          = bp.if_branch & bht_predict_taken(lookup_state);

  assign tgt_taken = bp.if_pc + bp.if_imm;       // wraps modulo 2^XLEN
  assign tgt_seq   = bp.if_pc + XLEN'(4);

  assign bp.branch_estimation       = est;
  assign bp.branch_target_predicted = est ? tgt_taken : tgt_seq;

  assign update_state = table_q[update_idx];

  bht_counter_next u_counter_next (
    .state_i (update_state),
    .taken_i (bp.ex_branch_taken),
    .state_o (update_state_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= BHT_WNT;
      end
    end else if (bp.ex_branch) begin
      table_q[update_idx] <= update_state_d;
    end
  end

  always_comb begin
    miss_count_d = miss_count_q;
    if (bp.ex_branch && bp.ex_branch_prediction_miss && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_count_q <= '0;
    end else begin
      miss_count_q <= miss_count_d;
    end
  end

  assign bp.miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a table-of-integers model plus
// directed vectors with literal expectations.
module tb_branch_predictor;

  logic clk;
  logic reset_n;

  branch_predictor_if #(.XLEN(32)) bp ();

  branch_predictor dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bp      (bp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Model: each table entry is an integer 0..3 (0=strongly not taken .. 3=strongly taken).
  int ctr [64];
  int miss_m;
  int ghr_m;

  function automatic int m_idx(logic [31:0] pc, int ghr);
    int i;
    i = int'((pc >> 2) % 64);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    i = i ^ ghr;
`endif
    return i;
  endfunction

  function automatic int m_step(int c, logic taken);
    if (taken) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) ctr[i] <= 1;
      miss_m <= 0;
      ghr_m  <= 0;
    end else if (bp.ex_branch) begin
      ctr[m_idx(bp.ex_pc, ghr_m)] <= m_step(ctr[m_idx(bp.ex_pc, ghr_m)], bp.ex_branch_taken);
      if (bp.ex_branch_prediction_miss && miss_m < 65535) miss_m <= miss_m + 1;
      ghr_m <= ((ghr_m * 2) + int'(bp.ex_branch_taken)) % 64;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      logic        e_est;
      logic [31:0] e_tgt;
      e_est = bp.if_branch && (ctr[m_idx(bp.if_pc, ghr_m)] >= 2);
      e_tgt = e_est ? (bp.if_pc + bp.if_imm) : (bp.if_pc + 32'd4);
      chk("model_est",  32'(bp.branch_estimation),  32'(e_est));
      chk("model_tgt",  bp.branch_target_predicted, e_tgt);
      chk("model_miss", 32'(bp.miss_count),         32'(miss_m));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One resolve strobe lasting exactly one rising edge.
  task automatic upd(logic [31:0] pc, logic taken, logic miss);
    bp.ex_branch                 = 1'b1;
    bp.ex_pc                     = pc;
    bp.ex_branch_taken           = taken;
    bp.ex_branch_prediction_miss = miss;
    tick();
    bp.ex_branch                 = 1'b0;
    bp.ex_branch_taken           = 1'b0;
    bp.ex_branch_prediction_miss = 1'b0;
  endtask

  task automatic lookup(logic [31:0] pc, logic [31:0] imm);
    bp.if_branch = 1'b1;
    bp.if_pc     = pc;
    bp.if_imm    = imm;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bp.if_branch                 = 1'b0;
    bp.if_pc                     = '0;
    bp.if_imm                    = '0;
    bp.ex_branch                 = 1'b0;
    bp.ex_pc                     = '0;
    bp.ex_branch_taken           = 1'b0;
    bp.ex_branch_prediction_miss = 1'b0;
    do_reset();

`ifndef BRANCH_PREDICTOR_GSHARE_EN
    // Fresh table is weakly not-taken everywhere.
    lookup(32'h1000, 32'h100);
    chk("reset_est",  32'(bp.branch_estimation), 32'd0);
    chk("reset_tgt",  bp.branch_target_predicted, 32'h0000_1004);
    chk("reset_miss", 32'(bp.miss_count),         32'd0);

    // One taken update: WNT -> WT.
    upd(32'h1000, 1'b1, 1'b1);
    #1;
    chk("upd1_est",  32'(bp.branch_estimation),  32'd1);
    chk("upd1_tgt",  bp.branch_target_predicted, 32'h0000_1100);
    chk("upd1_miss", 32'(bp.miss_count),         32'd1);

    // Saturate at ST, then walk back down.
    repeat (3) upd(32'h1000, 1'b1, 1'b0);
    upd(32'h1000, 1'b0, 1'b0);
    #1;
    chk("st_to_wt_est", 32'(bp.branch_estimation), 32'd1);
    upd(32'h1000, 1'b0, 1'b0);
    #1;
    chk("wt_to_wnt_est", 32'(bp.branch_estimation), 32'd0);

    // Aliasing: 0x1100 shares index 0 with 0x1000.
    upd(32'h1000, 1'b1, 1'b0);
    upd(32'h1000, 1'b1, 1'b0);
    lookup(32'h1100, 32'h100);
    chk("alias_est", 32'(bp.branch_estimation),  32'd1);
    chk("alias_tgt", bp.branch_target_predicted, 32'h0000_1200);

    // Back to WNT, then same-cycle update and lookup: no bypass.
    upd(32'h1000, 1'b0, 1'b0);
    upd(32'h1000, 1'b0, 1'b0);
    lookup(32'h1000, 32'h100);
    bp.ex_branch       = 1'b1;
    bp.ex_pc           = 32'h1000;
    bp.ex_branch_taken = 1'b1;
    #1;
    chk("samecyc_est_before", 32'(bp.branch_estimation), 32'd0);
    tick();
    bp.ex_branch       = 1'b0;
    bp.ex_branch_taken = 1'b0;
    #1;
    chk("samecyc_est_after", 32'(bp.branch_estimation), 32'd1);

    // Without ex_branch the taken/miss inputs are ignored.
    bp.ex_pc                     = 32'h1000;
    bp.ex_branch_taken           = 1'b0;
    bp.ex_branch_prediction_miss = 1'b1;
    tick();
    tick();
    bp.ex_branch_prediction_miss = 1'b0;
    chk("idle_est",  32'(bp.branch_estimation), 32'd1);
    chk("idle_miss", 32'(bp.miss_count),        32'd1);

    // Asynchronous reset between edges with an update pending across the edge.
    upd(32'h1000, 1'b1, 1'b1);           // ST, miss_count = 2
    bp.ex_branch                 = 1'b1;
    bp.ex_pc                     = 32'h1000;
    bp.ex_branch_taken           = 1'b1;
    bp.ex_branch_prediction_miss = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_est",  32'(bp.branch_estimation), 32'd0);
    chk("arst_miss", 32'(bp.miss_count),        32'd0);
    tick();
    bp.ex_branch                 = 1'b0;
    bp.ex_branch_taken           = 1'b0;
    bp.ex_branch_prediction_miss = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
    chk("arst_after_est", 32'(bp.branch_estimation), 32'd0);
    upd(32'h1000, 1'b1, 1'b0);           // WNT -> WT proves the entry was WNT
    #1;
    chk("arst_wnt_est", 32'(bp.branch_estimation), 32'd1);

    // Target sum wraps modulo 2^32 (0xFFFFFF00 also maps to index 0).
    lookup(32'hFFFF_FF00, 32'h0000_0200);
    chk("wrap_est", 32'(bp.branch_estimation),  32'd1);
    chk("wrap_tgt", bp.branch_target_predicted, 32'h0000_0100);

    // Unknown fetch fields on a non-branch must not reach the estimate.
    bp.if_branch = 1'b0;
    bp.if_pc     = 'x;
    bp.if_imm    = 'x;
    #1;
    chk("x_nonbranch_est", 32'(bp.branch_estimation), 32'd0);
    bp.if_pc     = 32'h1000;
    bp.if_imm    = 32'h100;
`else
    // Alternating outcome at one PC: after the history fills, every prediction is right.
    lookup(32'h1000, 32'h100);
    for (int k = 0; k < 12; k++) begin
      bp.ex_branch       = 1'b1;
      bp.ex_pc           = 32'h1000;
      bp.ex_branch_taken = (k % 2 == 0);
      #1;
      if (k >= 8) chk("gshare_pred", 32'(bp.branch_estimation), 32'((k % 2 == 0) ? 1 : 0));
      tick();
    end
    bp.ex_branch       = 1'b0;
    bp.ex_branch_taken = 1'b0;
    #1;
`endif

    // miss_count saturates at 0xFFFF.
    do_reset();
    lookup(32'h2000, 32'h40);
    bp.ex_branch                 = 1'b1;
    bp.ex_pc                     = 32'h2000;
    bp.ex_branch_taken           = 1'b1;
    bp.ex_branch_prediction_miss = 1'b1;
    repeat (65540) tick();
    bp.ex_branch                 = 1'b0;
    bp.ex_branch_taken           = 1'b0;
    bp.ex_branch_prediction_miss = 1'b0;
    #1;
    chk("miss_sat",       32'(bp.miss_count), 32'h0000_FFFF);
    chk("miss_sat_model", 32'(miss_m),        32'd65535);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
